// File: rtl/enemy_fleet_ctrl.sv
// Enemy fleet controller: N independent enemy channels that wait, spawn, march
// along x towards the end of the map, and report escapes and kills.
module enemy_fleet_ctrl #(
    parameter int unsigned N_ENEMIES     = 3,
    parameter int unsigned XW            = 8,
    parameter int unsigned X_START       = 0,
    parameter int unsigned X_END         = 255,
    parameter int unsigned SPAWN_DELAY   = 1000,
    parameter int unsigned SPAWN_STAGGER = 200,
    parameter int unsigned MOVE_PERIOD   = 1000,
    parameter int unsigned STEP          = 1,
    parameter int unsigned RESPAWN       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause,
    input  logic [N_ENEMIES-1:0]    kill,
    output logic [N_ENEMIES*XW-1:0] x_enemy,
    output logic [N_ENEMIES-1:0]    spawn,
    output logic [N_ENEMIES-1:0]    end_pulse,
    output logic                    all_end,
    output logic [7:0]              escape_cnt,
    output logic [7:0]              kill_cnt
);

    localparam int unsigned D_MAX  = SPAWN_DELAY + (N_ENEMIES - 1) * SPAWN_STAGGER;
    localparam int unsigned DW     = (D_MAX > 1) ? $clog2(D_MAX) : 1;
    localparam int unsigned MW     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int unsigned M_LAST = (MOVE_PERIOD > 1) ? MOVE_PERIOD - 1 : 0;
    localparam int unsigned CW     = 4;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_FLY  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q [N_ENEMIES];
    state_e               state_d [N_ENEMIES];
    logic [DW-1:0]        dcnt_q  [N_ENEMIES];
    logic [DW-1:0]        dcnt_d  [N_ENEMIES];
    logic [MW-1:0]        mcnt_q  [N_ENEMIES];
    logic [MW-1:0]        mcnt_d  [N_ENEMIES];
    logic [XW-1:0]        x_q     [N_ENEMIES];
    logic [XW-1:0]        x_d     [N_ENEMIES];
    logic [N_ENEMIES-1:0] spawn_q;
    logic [N_ENEMIES-1:0] spawn_d;
    logic [N_ENEMIES-1:0] end_q;
    logic [N_ENEMIES-1:0] end_d;
    logic [7:0]           esc_q;
    logic [7:0]           esc_d;
    logic [7:0]           kcnt_q;
    logic [7:0]           kcnt_d;
    logic [XW:0]          step_sum;
    logic [CW-1:0]        n_end;
    logic [CW-1:0]        n_kill;

    // Last delay-counter value before channel ch spawns (a zero delay behaves as one).
    function automatic logic [DW-1:0] delay_last(input int unsigned ch);
        int unsigned d;
        d = SPAWN_DELAY + ch * SPAWN_STAGGER;
        return (d == 0) ? '0 : DW'(d - 1);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CW-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Per-channel next state; a kill in FLY takes priority over reaching the end.
    always_comb begin
        spawn_d  = '0;
        end_d    = '0;
        n_end    = '0;
        n_kill   = '0;
        step_sum = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            mcnt_d[i]  = mcnt_q[i];
            x_d[i]     = x_q[i];
            if (!pause) begin
                case (state_q[i])
                    S_WAIT: begin
                        if (dcnt_q[i] == delay_last(i)) begin
                            state_d[i] = S_FLY;
                            dcnt_d[i]  = '0;
                            mcnt_d[i]  = '0;
                            x_d[i]     = XW'(X_START);
                        end else begin
                            dcnt_d[i] = dcnt_q[i] + DW'(1);
                        end
                    end
                    S_FLY: begin
                        if (kill[i]) begin
                            state_d[i] = S_WAIT;
                            dcnt_d[i]  = '0;
                            mcnt_d[i]  = '0;
                            x_d[i]     = XW'(X_START);
                            n_kill     = n_kill + CW'(1);
                        end else if (x_q[i] == XW'(X_END)) begin
                            end_d[i]  = 1'b1;
                            n_end     = n_end + CW'(1);
                            dcnt_d[i] = '0;
                            mcnt_d[i] = '0;
                            if (RESPAWN != 0) begin
                                state_d[i] = S_WAIT;
                                x_d[i]     = XW'(X_START);
                            end else begin
                                state_d[i] = S_DONE;
                            end
                        end else if (mcnt_q[i] == MW'(M_LAST)) begin
                            mcnt_d[i] = '0;
                            step_sum  = {1'b0, x_q[i]} + (XW + 1)'(STEP);
                            if (step_sum >= (XW + 1)'(X_END)) begin
                                x_d[i] = XW'(X_END);
                            end else begin
                                x_d[i] = step_sum[XW-1:0];
                            end
                        end else begin
                            mcnt_d[i] = mcnt_q[i] + MW'(1);
                        end
                    end
                    default: begin
                        x_d[i] = XW'(X_END);
                    end
                endcase
            end
            spawn_d[i] = (state_d[i] == S_FLY);
        end
        esc_d  = sat_add(esc_q, n_end);
        kcnt_d = sat_add(kcnt_q, n_kill);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ENEMIES; i++) begin
                state_q[i] <= S_WAIT;
                dcnt_q[i]  <= '0;
                mcnt_q[i]  <= '0;
                x_q[i]     <= XW'(X_START);
            end
            spawn_q <= '0;
            end_q   <= '0;
            esc_q   <= '0;
            kcnt_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENEMIES; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                mcnt_q[i]  <= mcnt_d[i];
                x_q[i]     <= x_d[i];
            end
            spawn_q <= spawn_d;
            end_q   <= end_d;
            esc_q   <= esc_d;
            kcnt_q  <= kcnt_d;
        end
    end

    always_comb begin
        x_enemy = '0;
        all_end = (RESPAWN == 0);
        for (int unsigned i = 0; i < N_ENEMIES; i++) begin
            x_enemy[i*XW +: XW] = x_q[i];
            all_end             = all_end & (state_q[i] == S_DONE);
        end
    end

    assign spawn      = spawn_q;
    assign end_pulse  = end_q;
    assign escape_cnt = esc_q;
    assign kill_cnt   = kcnt_q;

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Directed bench for enemy_fleet_ctrl: base, STEP=3 and RESPAWN=1 instances.
module tb_enemy_fleet_ctrl;

    logic clk;
    int   total;
    int   bad;

    logic        rst_a, pause_a, alle_a;
    logic [2:0]  kill_a, spawn_a, endp_a;
    logic [23:0] x_a;
    logic [7:0]  esc_a, kcnt_a;

    logic        rst_b, pause_b, alle_b;
    logic [2:0]  kill_b, spawn_b, endp_b;
    logic [23:0] x_b;
    logic [7:0]  esc_b, kcnt_b;

    logic        rst_c, pause_c, alle_c;
    logic [2:0]  kill_c, spawn_c, endp_c;
    logic [23:0] x_c;
    logic [7:0]  esc_c, kcnt_c;

    enemy_fleet_ctrl #(.N_ENEMIES(3), .XW(8), .X_START(0), .X_END(20), .SPAWN_DELAY(10),
        .SPAWN_STAGGER(5), .MOVE_PERIOD(4), .STEP(1), .RESPAWN(0)) u_dut (
        .clk(clk), .rst(rst_a), .pause(pause_a), .kill(kill_a), .x_enemy(x_a),
        .spawn(spawn_a), .end_pulse(endp_a), .all_end(alle_a),
        .escape_cnt(esc_a), .kill_cnt(kcnt_a));

    enemy_fleet_ctrl #(.N_ENEMIES(3), .XW(8), .X_START(0), .X_END(20), .SPAWN_DELAY(10),
        .SPAWN_STAGGER(5), .MOVE_PERIOD(4), .STEP(3), .RESPAWN(0)) u_dut_s3 (
        .clk(clk), .rst(rst_b), .pause(pause_b), .kill(kill_b), .x_enemy(x_b),
        .spawn(spawn_b), .end_pulse(endp_b), .all_end(alle_b),
        .escape_cnt(esc_b), .kill_cnt(kcnt_b));

    enemy_fleet_ctrl #(.N_ENEMIES(3), .XW(8), .X_START(0), .X_END(20), .SPAWN_DELAY(10),
        .SPAWN_STAGGER(5), .MOVE_PERIOD(4), .STEP(1), .RESPAWN(1)) u_dut_rs (
        .clk(clk), .rst(rst_c), .pause(pause_c), .kill(kill_c), .x_enemy(x_c),
        .spawn(spawn_c), .end_pulse(endp_c), .all_end(alle_c),
        .escape_cnt(esc_c), .kill_cnt(kcnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_a = 1'b1; pause_a = 1'b1; kill_a = 3'b111;
        repeat (3) @(negedge clk);
        total++; if (x_a !== 24'd0) begin bad++; $display("FAIL reset_x got=%h exp=%h", x_a, 24'd0); end
        total++; if ({spawn_a, endp_a, alle_a} !== 7'd0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", {spawn_a, endp_a, alle_a}, 7'd0); end
        total++; if ({esc_a, kcnt_a} !== 16'd0) begin bad++; $display("FAIL reset_cnts got=%h exp=%h", {esc_a, kcnt_a}, 16'd0); end
        rst_a = 1'b0; pause_a = 1'b0; kill_a = 3'b000;
    endtask

    task automatic test_spawn();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 9) begin
                total++; if (spawn_a !== 3'b000) begin bad++; $display("FAIL spawn_c9 got=%b exp=%b", spawn_a, 3'b000); end
            end
            if (c == 10) begin
                total++; if (spawn_a !== 3'b001) begin bad++; $display("FAIL spawn_c10 got=%b exp=%b", spawn_a, 3'b001); end
                total++; if (x_a[7:0] !== 8'd0) begin bad++; $display("FAIL x0_c10 got=%0d exp=%0d", x_a[7:0], 0); end
            end
            if (c == 13) begin
                total++; if (x_a[7:0] !== 8'd0) begin bad++; $display("FAIL x0_c13 got=%0d exp=%0d", x_a[7:0], 0); end
            end
            if (c == 14) begin
                total++; if (x_a[7:0] !== 8'd1) begin bad++; $display("FAIL x0_c14 got=%0d exp=%0d", x_a[7:0], 1); end
                total++; if (spawn_a !== 3'b001) begin bad++; $display("FAIL spawn_c14 got=%b exp=%b", spawn_a, 3'b001); end
            end
            if (c == 15) begin
                total++; if (spawn_a !== 3'b011) begin bad++; $display("FAIL spawn_c15 got=%b exp=%b", spawn_a, 3'b011); end
            end
            if (c == 18) begin
                total++; if (x_a[7:0] !== 8'd2) begin bad++; $display("FAIL x0_c18 got=%0d exp=%0d", x_a[7:0], 2); end
            end
            if (c == 19) begin
                total++; if (spawn_a !== 3'b011) begin bad++; $display("FAIL spawn_c19 got=%b exp=%b", spawn_a, 3'b011); end
            end
            if (c == 20) begin
                total++; if (spawn_a !== 3'b111) begin bad++; $display("FAIL spawn_c20 got=%b exp=%b", spawn_a, 3'b111); end
            end
        end
    endtask

    task automatic test_free_run();
        int ep0, ep1, ep2;
        ep0 = 0; ep1 = 0; ep2 = 0;
        for (int c = 21; c <= 110; c++) begin
            @(negedge clk);
            ep0 += int'(endp_a[0]); ep1 += int'(endp_a[1]); ep2 += int'(endp_a[2]);
            if (c == 89) begin
                total++; if (x_a[7:0] !== 8'd19) begin bad++; $display("FAIL x0_c89 got=%0d exp=%0d", x_a[7:0], 19); end
            end
            if (c == 90) begin
                total++; if (x_a[7:0] !== 8'd20) begin bad++; $display("FAIL x0_c90 got=%0d exp=%0d", x_a[7:0], 20); end
                total++; if ({spawn_a[0], endp_a} !== 4'b1000) begin bad++; $display("FAIL fly_c90 got=%b exp=%b", {spawn_a[0], endp_a}, 4'b1000); end
            end
            if (c == 91) begin
                total++; if (endp_a !== 3'b001) begin bad++; $display("FAIL endp_c91 got=%b exp=%b", endp_a, 3'b001); end
                total++; if (spawn_a !== 3'b110) begin bad++; $display("FAIL spawn_c91 got=%b exp=%b", spawn_a, 3'b110); end
                total++; if (esc_a !== 8'd1) begin bad++; $display("FAIL esc_c91 got=%0d exp=%0d", esc_a, 1); end
            end
            if (c == 96) begin
                total++; if (endp_a !== 3'b010 || esc_a !== 8'd2) begin bad++; $display("FAIL end1_c96 got=%b/%0d exp=%b/%0d", endp_a, esc_a, 3'b010, 2); end
            end
            if (c == 100) begin
                total++; if (alle_a !== 1'b0) begin bad++; $display("FAIL alle_c100 got=%b exp=%b", alle_a, 1'b0); end
            end
            if (c == 101) begin
                total++; if (endp_a !== 3'b100 || alle_a !== 1'b1) begin bad++; $display("FAIL end2_c101 got=%b/%b exp=%b/%b", endp_a, alle_a, 3'b100, 1'b1); end
                total++; if (esc_a !== 8'd3 || spawn_a !== 3'b000) begin bad++; $display("FAIL done_c101 got=%0d/%b exp=%0d/%b", esc_a, spawn_a, 3, 3'b000); end
            end
        end
        total++; if (x_a !== {8'd20, 8'd20, 8'd20}) begin bad++; $display("FAIL x_hold got=%h exp=%h", x_a, {8'd20, 8'd20, 8'd20}); end
        total++; if (ep0 != 1 || ep1 != 1 || ep2 != 1) begin bad++; $display("FAIL pulse_count got=%0d,%0d,%0d exp=1,1,1", ep0, ep1, ep2); end
        total++; if (alle_a !== 1'b1 || esc_a !== 8'd3) begin bad++; $display("FAIL final_state got=%b/%0d exp=1/3", alle_a, esc_a); end
    endtask

    task automatic test_kill();
        rst_a = 1'b1; pause_a = 1'b0; kill_a = 3'b000;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            kill_a = 3'b000;
            if (c == 43) begin
                total++; if (x_a[15:8] !== 8'd7) begin bad++; $display("FAIL x1_c43 got=%0d exp=%0d", x_a[15:8], 7); end
                kill_a = 3'b010;
            end
            if (c == 44) begin
                total++; if (spawn_a !== 3'b101) begin bad++; $display("FAIL kill_spawn got=%b exp=%b", spawn_a, 3'b101); end
                total++; if (x_a[15:8] !== 8'd0 || x_a[7:0] !== 8'd8) begin bad++; $display("FAIL kill_x got=%0d/%0d exp=0/8", x_a[15:8], x_a[7:0]); end
                total++; if (kcnt_a !== 8'd1) begin bad++; $display("FAIL kill_cnt1 got=%0d exp=%0d", kcnt_a, 1); end
            end
            if (c == 50) kill_a = 3'b010;
            if (c == 51) begin
                total++; if (kcnt_a !== 8'd1 || spawn_a[1] !== 1'b0) begin bad++; $display("FAIL kill_wait got=%0d/%b exp=1/0", kcnt_a, spawn_a[1]); end
            end
            if (c == 58) begin
                total++; if (spawn_a[1] !== 1'b0) begin bad++; $display("FAIL respawn_c58 got=%b exp=%b", spawn_a[1], 1'b0); end
            end
            if (c == 59) begin
                total++; if (spawn_a[1] !== 1'b1) begin bad++; $display("FAIL respawn_c59 got=%b exp=%b", spawn_a[1], 1'b1); end
            end
        end
    endtask

    task automatic test_kill_at_end();
        for (int c = 61; c <= 103; c++) begin
            @(negedge clk);
            kill_a = 3'b000;
            if (c == 90) begin
                total++; if (x_a[7:0] !== 8'd20) begin bad++; $display("FAIL ke_x0_c90 got=%0d exp=%0d", x_a[7:0], 20); end
                kill_a = 3'b001;
            end
            if (c == 91) begin
                total++; if (endp_a !== 3'b000 || esc_a !== 8'd0) begin bad++; $display("FAIL ke_noend got=%b/%0d exp=000/0", endp_a, esc_a); end
                total++; if (kcnt_a !== 8'd2) begin bad++; $display("FAIL ke_kcnt got=%0d exp=%0d", kcnt_a, 2); end
                total++; if (x_a[7:0] !== 8'd0 || spawn_a[0] !== 1'b0) begin bad++; $display("FAIL ke_wait got=%0d/%b exp=0/0", x_a[7:0], spawn_a[0]); end
            end
            if (c == 101) begin
                total++; if (spawn_a[0] !== 1'b1 || endp_a !== 3'b100 || esc_a !== 8'd1) begin bad++; $display("FAIL ke_c101 got=%b/%b/%0d exp=1/100/1", spawn_a[0], endp_a, esc_a); end
            end
            if (c == 102) kill_a = 3'b111;
            if (c == 103) begin
                total++; if (kcnt_a !== 8'd4) begin bad++; $display("FAIL multi_kill got=%0d exp=%0d", kcnt_a, 4); end
                total++; if (spawn_a !== 3'b000 || x_a[23:16] !== 8'd20) begin bad++; $display("FAIL multi_state got=%b/%0d exp=000/20", spawn_a, x_a[23:16]); end
            end
        end
        kill_a = 3'b000;
    endtask

    task automatic test_step3_pause();
        rst_b = 1'b1; pause_b = 1'b0; kill_b = 3'b000;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            if (c == 10 && x_b[7:0] !== 8'd0) begin bad++; $display("FAIL s3_c10 got=%0d exp=0", x_b[7:0]); end
            if (c == 14 && x_b[7:0] !== 8'd3) begin bad++; $display("FAIL s3_c14 got=%0d exp=3", x_b[7:0]); end
            if (c == 18 && x_b[7:0] !== 8'd6) begin bad++; $display("FAIL s3_c18 got=%0d exp=6", x_b[7:0]); end
            if (c == 19 && x_b[15:8] !== 8'd3) begin bad++; $display("FAIL s3_x1_c19 got=%0d exp=3", x_b[15:8]); end
            if (c == 24 && (x_b[7:0] !== 8'd6 || x_b[15:8] !== 8'd3)) begin bad++; $display("FAIL pause_x got=%0d/%0d exp=6/3", x_b[7:0], x_b[15:8]); end
            if (c == 24 && (kcnt_b !== 8'd0 || spawn_b !== 3'b111)) begin bad++; $display("FAIL pause_kill got=%0d/%b exp=0/111", kcnt_b, spawn_b); end
            if (c == 28 && x_b[7:0] !== 8'd6) begin bad++; $display("FAIL pause_c28 got=%0d exp=6", x_b[7:0]); end
            if (c == 30 && x_b[7:0] !== 8'd9) begin bad++; $display("FAIL s3_c30 got=%0d exp=9", x_b[7:0]); end
            if (c == 31 && (x_b[15:8] !== 8'd6 || x_b[23:16] !== 8'd0)) begin bad++; $display("FAIL s3_c31 got=%0d/%0d exp=6/0", x_b[15:8], x_b[23:16]); end
            if (c == 32 && x_b[23:16] !== 8'd3) begin bad++; $display("FAIL s3_x2_c32 got=%0d exp=3", x_b[23:16]); end
            if (c == 42 && x_b[7:0] !== 8'd18) begin bad++; $display("FAIL s3_c42 got=%0d exp=18", x_b[7:0]); end
            if (c == 46 && (x_b[7:0] !== 8'd20 || endp_b !== 3'b000)) begin bad++; $display("FAIL s3_clamp got=%0d/%b exp=20/000", x_b[7:0], endp_b); end
            if (c == 47 && (endp_b !== 3'b001 || esc_b !== 8'd1)) begin bad++; $display("FAIL s3_end got=%b/%0d exp=001/1", endp_b, esc_b); end
            if (c == 10 || c == 14 || c == 18 || c == 19 || c == 28 || c == 30 || c == 31 ||
                c == 32 || c == 42 || c == 46 || c == 47) total++;
            if (c == 24) total += 2;
            if (c == 20) pause_b = 1'b1;
            if (c == 22) kill_b = 3'b010;
            if (c == 23) kill_b = 3'b000;
            if (c == 28) pause_b = 1'b0;
        end
    endtask

    task automatic test_respawn_reset();
        rst_c = 1'b1; pause_c = 1'b0; kill_c = 3'b000;
        repeat (2) @(negedge clk);
        rst_c = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (spawn_c !== 3'b111) begin bad++; $display("FAIL rs_pre got=%b exp=%b", spawn_c, 3'b111); end
        rst_c = 1'b1; pause_c = 1'b1; kill_c = 3'b111;
        @(negedge clk);
        total++; if (x_c !== 24'd0 || {spawn_c, endp_c, alle_c} !== 7'd0) begin bad++; $display("FAIL rs_reset got=%h/%b exp=0/0", x_c, {spawn_c, endp_c, alle_c}); end
        total++; if ({esc_c, kcnt_c} !== 16'd0) begin bad++; $display("FAIL rs_cnts got=%h exp=%h", {esc_c, kcnt_c}, 16'd0); end
        rst_c = 1'b0; pause_c = 1'b0; kill_c = 3'b000;
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (c == 9) begin
                total++; if (spawn_c !== 3'b000) begin bad++; $display("FAIL rs_c9 got=%b exp=%b", spawn_c, 3'b000); end
            end
            if (c == 10) begin
                total++; if (spawn_c !== 3'b001) begin bad++; $display("FAIL rs_c10 got=%b exp=%b", spawn_c, 3'b001); end
            end
            if (c == 15) begin
                total++; if (spawn_c !== 3'b011) begin bad++; $display("FAIL rs_c15 got=%b exp=%b", spawn_c, 3'b011); end
            end
            if (c == 20) begin
                total++; if (spawn_c !== 3'b111) begin bad++; $display("FAIL rs_c20 got=%b exp=%b", spawn_c, 3'b111); end
            end
            if (c == 90) begin
                total++; if (x_c[7:0] !== 8'd20) begin bad++; $display("FAIL rs_x0_c90 got=%0d exp=%0d", x_c[7:0], 20); end
            end
            if (c == 91) begin
                total++; if (endp_c !== 3'b001 || x_c[7:0] !== 8'd0) begin bad++; $display("FAIL rs_loop got=%b/%0d exp=001/0", endp_c, x_c[7:0]); end
                total++; if (spawn_c !== 3'b110 || esc_c !== 8'd1 || alle_c !== 1'b0) begin bad++; $display("FAIL rs_c91 got=%b/%0d/%b exp=110/1/0", spawn_c, esc_c, alle_c); end
            end
            if (c == 101) begin
                total++; if (spawn_c[0] !== 1'b1 || endp_c !== 3'b100) begin bad++; $display("FAIL rs_c101 got=%b/%b exp=1/100", spawn_c[0], endp_c); end
                total++; if (esc_c !== 8'd3 || alle_c !== 1'b0) begin bad++; $display("FAIL rs_alle got=%0d/%b exp=3/0", esc_c, alle_c); end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_a = 1'b1; pause_a = 1'b0; kill_a = 3'b000;
        rst_b = 1'b1; pause_b = 1'b0; kill_b = 3'b000;
        rst_c = 1'b1; pause_c = 1'b0; kill_c = 3'b000;
        test_reset();
        test_spawn();
        test_free_run();
        test_kill();
        test_kill_at_end();
        test_step3_pause();
        test_respawn_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_fleet_ctrl.md
ENEMY_FLEET_CTRL -- requirements
Module: enemy_fleet_ctrl

Interface
REQ-001 Parameter N_ENEMIES, default 3: number of independent enemy channels, 1..8.
REQ-002 Parameter XW, default 8: position width in bits, matching the DAC width.
REQ-003 Parameter X_START, default 0: spawn x position.
REQ-004 Parameter X_END, default 255: end-of-map x position; must exceed X_START.
REQ-005 Parameter SPAWN_DELAY, default 1000: cycles from WAIT entry to spawn for channel 0.
REQ-006 Parameter SPAWN_STAGGER, default 200: extra spawn-delay cycles per channel index.
REQ-007 Parameter MOVE_PERIOD, default 1000: cycles between position steps.
REQ-008 Parameter STEP, default 1: x increment per move, 1..X_END-X_START.
REQ-009 Parameter RESPAWN, default 0: 0 is one-shot, 1 is loop.
REQ-010 clk  input  1  sole clock; all logic on its rising edge.
REQ-011 rst  input  1  synchronous, active-high reset.
REQ-012 pause  input  1  freezes every counter and position while high.
REQ-013 kill  input  N_ENEMIES  per-channel destroy request, sampled each cycle.
REQ-014 x_enemy  output  N_ENEMIES*XW  packed positions, channel i at bits [i*XW +: XW].
REQ-015 spawn  output  N_ENEMIES  high while channel is in FLY.
REQ-016 end_pulse  output  N_ENEMIES  one-cycle strobe when channel reaches X_END.
REQ-017 all_end  output  1  high while every channel is in DONE.
REQ-018 escape_cnt  output  8  saturating count of end-of-map arrivals.
REQ-019 kill_cnt  output  8  saturating count of accepted kills.

Function
REQ-020 Each channel SHALL run an independent FSM with states WAIT, FLY and DONE.
REQ-021 WAIT: the delay counter SHALL count to D_i = SPAWN_DELAY + i*SPAWN_STAGGER; after D_i non-paused cycles in WAIT → FLY, with spawn[i] high in the first FLY cycle and x = X_START.
REQ-022 FLY: the move counter SHALL advance once per non-paused cycle; every MOVE_PERIOD counts x SHALL step by STEP and the counter SHALL return to 0.
REQ-023 Step arithmetic SHALL use XW+1 bits; if x+STEP >= X_END then x SHALL become exactly X_END, never wrapping.
REQ-024 The cycle after x becomes X_END: end_pulse[i]=1 for exactly one cycle, escape_cnt +1, spawn[i] low, state → DONE (RESPAWN=0) or → WAIT with x=X_START (RESPAWN=1).
REQ-025 DONE SHALL hold x at X_END; the state is left only by reset.
REQ-026 kill[i] high in FLY: next cycle state WAIT, x=X_START, counters 0, spawn[i] low, kill_cnt +1; kill[i] in WAIT or DONE SHALL be ignored.
REQ-027 Kill and end-of-map in the same cycle: kill wins; no end_pulse and no escape_cnt increment.
REQ-028 Multiple simultaneous end events SHALL increase escape_cnt by the number of events; multiple simultaneous kills SHALL increase kill_cnt by the number of kills; both counters saturate at 255.
REQ-029 pause SHALL freeze counters, positions, states and counts; kill is ignored while paused; end_pulse SHALL NOT be asserted while paused.
REQ-030 all_end SHALL be combinational AND of per-channel DONE; it is always 0 when RESPAWN=1.

Reset
REQ-031 With rst high at a clock edge, next cycle: all states WAIT, x_enemy all X_START, spawn 0, end_pulse 0, all_end 0, escape_cnt 0, kill_cnt 0, all counters 0.
REQ-032 Reset SHALL override pause, kill and any in-flight or DONE state.

Verification
Bench parameters: N_ENEMIES=3, SPAWN_DELAY=10, SPAWN_STAGGER=5, MOVE_PERIOD=4, STEP=1, X_START=0, X_END=20, RESPAWN=0.
REQ-033 Reset release → spawn[0] rises 10 cycles later, spawn[1] at 15 cycles, spawn[2] at 20 cycles; x steps 0,1,2 every 4 cycles.
REQ-034 Free run → each channel reaches x=20 after 80 FLY cycles with a single end_pulse; all_end rises after channel 2 ends; escape_cnt=3; x held at 20.
REQ-035 kill[1] when x1=7 → next cycle spawn[1]=0, x1=0, kill_cnt=1; channel 1 respawns 15 cycles later; kill[1] applied in WAIT changes nothing.
REQ-036 kill[0] in the cycle x0 steps to 20 → no end_pulse[0], escape_cnt unchanged, kill_cnt +1, channel 0 back in WAIT.
REQ-037 STEP=3, X_END=20 → x sequence 0,3,...,18,20 (clamped); pause held 8 cycles mid-flight → x frozen, all later events shifted by 8 cycles.
REQ-038 rst pulsed mid-flight with RESPAWN=1 → all outputs at REQ-031 values next cycle; spawn sequence restarts as in REQ-033.
